// File: rtl/mem_pkg.sv
// Shared types for the sub-word load/store front-end.
package mem_pkg;

    // Access size as carried on req_size.
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} mem_size_e;

    // Controller states. The read-modify-write merge is done combinationally
    // on the WAIT sample edge, so a sub-word store goes WAIT -> WR directly.
    typedef enum logic [2:0] {
        ST_IDLE, ST_ERR, ST_RD, ST_WAIT, ST_WR, ST_RESP
    } mem_state_e;

    // Widest supported memory word, in byte lanes.
    localparam int LANE_BYTES = 8;

    // Number of bytes touched by an access of the given size.
    function automatic logic [$clog2(LANE_BYTES):0] size_bytes(input mem_size_e s);
        return ($clog2(LANE_BYTES)+1)'(1) << s;
    endfunction

endpackage

// File: rtl/lane_merge_extract.sv
// Byte-lane steering: merges store data into a read word and extracts/extends
// a load field. Purely combinational.
module lane_merge_extract
    import mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OFF_W  = $clog2(DATA_W/8)
) (
    input  logic [DATA_W-1:0] word,
    input  logic [OFF_W-1:0]  offset,
    input  mem_size_e         size,
    input  logic              sgn,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] merged,
    output logic [DATA_W-1:0] loaded
);
    localparam int WB = DATA_W/8;

    logic [DATA_W-1:0] mask;
    logic [DATA_W-1:0] field;
    logic [OFF_W+2:0]  sh;
    logic              sign;

    // Build the field mask, then shift lanes in/out by the byte offset.
    always_comb begin
        mask = '0;
        for (int b = 0; b < WB; b++) begin
            if (b < int'(size_bytes(size))) mask[8*b +: 8] = 8'hFF;
        end
        sh     = {offset, 3'b000};
        field  = (word >> sh) & mask;
        // top bit of the mask marks the field's MSB
        sign   = |(field & (mask ^ (mask >> 1)));
        loaded = field | ((sgn && sign) ? ~mask : '0);
        merged = (word & ~(mask << sh)) | ((wdata & mask) << sh);
    end

endmodule

// File: rtl/subword_mem_port.sv
// Sequential load/store front-end: aligns CPU accesses onto a word-wide memory,
// doing read-modify-write for sub-word stores and flagging misaligned requests.
module subword_mem_port
    import mem_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int MEM_RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int WB    = DATA_W/8;
    localparam int OFF_W = $clog2(WB);
    localparam int CNT_W = $clog2(MEM_RD_LAT+1);

    mem_state_e        state, state_nxt;
    logic              we_q, sgn_q;
    mem_size_e         size_q;
    logic [OFF_W-1:0]  off_q;
    logic [DATA_W-1:0] wdata_q;
    logic [CNT_W-1:0]  cnt;

    logic [3:0]        nbytes;
    logic              misal, too_big, full_w, req_err, accept, sample;
    logic [DATA_W-1:0] merged, loaded;

    // Classify the incoming request and find the read-data sample cycle.
    always_comb begin
        nbytes  = size_bytes(mem_size_e'(req_size));
        misal   = |(req_addr[2:0] & 3'(nbytes - 4'd1));
        too_big = nbytes > 4'(WB);
        full_w  = nbytes == 4'(WB);
        req_err = misal | too_big;
        accept  = req_valid && (state == ST_IDLE);
        sample  = (state == ST_WAIT) && (cnt == CNT_W'(MEM_RD_LAT-1));
    end

    lane_merge_extract #(.DATA_W(DATA_W), .OFF_W(OFF_W)) u_lane (
        .word   (mem_rdata),
        .offset (off_q),
        .size   (size_q),
        .sgn    (sgn_q),
        .wdata  (wdata_q),
        .merged (merged),
        .loaded (loaded)
    );

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (req_valid) begin
                if (req_err)                state_nxt = ST_ERR;
                else if (req_we && full_w)  state_nxt = ST_WR;
                else                        state_nxt = ST_RD;
            end
            ST_ERR:  state_nxt = rsp_ready ? ST_IDLE : ST_RESP;
            ST_RD:   state_nxt = ST_WAIT;
            ST_WAIT: if (sample) state_nxt = we_q ? ST_WR : ST_RESP;
            ST_WR:   state_nxt = ST_RESP;
            ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State, latched request and registered outputs (strobes decoded from next state).
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            mem_addr  <= '0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_wdata <= '0;
            we_q      <= 1'b0;
            sgn_q     <= 1'b0;
            size_q    <= SZ_B;
            off_q     <= '0;
            wdata_q   <= '0;
            cnt       <= '0;
        end else begin
            state     <= state_nxt;
            req_ready <= state_nxt == ST_IDLE;
            mem_rd    <= state_nxt == ST_RD;
            mem_wr    <= state_nxt == ST_WR;
            rsp_valid <= (state_nxt == ST_ERR) || (state_nxt == ST_RESP);

            if (accept) begin
                we_q      <= req_we;
                sgn_q     <= req_signed;
                size_q    <= mem_size_e'(req_size);
                off_q     <= req_addr[OFF_W-1:0];
                wdata_q   <= req_wdata;
                mem_addr  <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                rsp_err   <= req_err;
                rsp_rdata <= '0;
                if (req_we && full_w) mem_wdata <= req_wdata;
            end

            if (state == ST_RD)        cnt <= '0;
            else if (state == ST_WAIT) cnt <= cnt + 1'b1;

            if (state == ST_WR) mem_wdata <= '0;
            if (sample) begin
                if (we_q) mem_wdata <= merged;
                else      rsp_rdata <= loaded;
            end

            if (rsp_valid && rsp_ready) begin
                rsp_rdata <= '0;
                rsp_err   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_subword_mem_port.sv
// Bench for subword_mem_port: a 32-bit/LAT1 and a 64-bit/LAT3 instance share
// one byte-array memory; cfg selects which one is driven. Expected results come
// from a byte-level reference memory and the access rules.
module tb_subword_mem_port;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, cfg;
    logic        req_valid, req_we, req_signed, rsp_ready;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [63:0] req_wdata;
    logic [63:0] mem_rdata_m;

    logic        a_req_ready, a_rsp_valid, a_rsp_err, a_mem_rd, a_mem_wr;
    logic [31:0] a_rsp_rdata, a_mem_addr, a_mem_wdata;
    logic        b_req_ready, b_rsp_valid, b_rsp_err, b_mem_rd, b_mem_wr;
    logic [63:0] b_rsp_rdata, b_mem_wdata;
    logic [31:0] b_mem_addr;

    subword_mem_port #(.DATA_W(32), .ADDR_W(32), .MEM_RD_LAT(1)) dut_a (
        .clk(clk), .reset(reset),
        .req_valid(req_valid && !cfg), .req_ready(a_req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata[31:0]), .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready || cfg),
        .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err), .mem_addr(a_mem_addr),
        .mem_rd(a_mem_rd), .mem_wr(a_mem_wr), .mem_wdata(a_mem_wdata),
        .mem_rdata(mem_rdata_m[31:0])
    );

    subword_mem_port #(.DATA_W(64), .ADDR_W(32), .MEM_RD_LAT(3)) dut_b (
        .clk(clk), .reset(reset),
        .req_valid(req_valid && cfg), .req_ready(b_req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready || !cfg),
        .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err), .mem_addr(b_mem_addr),
        .mem_rd(b_mem_rd), .mem_wr(b_mem_wr), .mem_wdata(b_mem_wdata),
        .mem_rdata(mem_rdata_m)
    );

    // Outputs of whichever instance is active.
    logic        c_req_ready, c_rsp_valid, c_rsp_err, c_mem_rd, c_mem_wr;
    logic [63:0] c_rsp_rdata, c_mem_wdata;
    logic [31:0] c_mem_addr;
    logic [3:0]  lat, dwb;
    assign c_req_ready = cfg ? b_req_ready : a_req_ready;
    assign c_rsp_valid = cfg ? b_rsp_valid : a_rsp_valid;
    assign c_rsp_err   = cfg ? b_rsp_err   : a_rsp_err;
    assign c_rsp_rdata = cfg ? b_rsp_rdata : {32'h0, a_rsp_rdata};
    assign c_mem_addr  = cfg ? b_mem_addr  : a_mem_addr;
    assign c_mem_rd    = cfg ? b_mem_rd    : a_mem_rd;
    assign c_mem_wr    = cfg ? b_mem_wr    : a_mem_wr;
    assign c_mem_wdata = cfg ? b_mem_wdata : {32'h0, a_mem_wdata};
    assign lat         = cfg ? 4'd3 : 4'd1;
    assign dwb         = cfg ? 4'd8 : 4'd4;

    // Memory model: 256 bytes aliased over the whole address space.
    logic [7:0]  mem_b [0:255];
    logic [31:0] rd_addr;
    logic [3:0]  rd_cnt;

    function automatic logic [63:0] rd_word(input logic [31:0] a);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = mem_b[8'(a + 32'(i))];
        return r;
    endfunction

    // Read data appears exactly lat cycles after mem_rd; junk at all other times.
    always @(posedge clk) begin
        if (c_mem_wr)
            for (int i = 0; i < 8; i++)
                if (i < int'(dwb)) mem_b[8'(c_mem_addr + 32'(i))] <= c_mem_wdata[8*i +: 8];
        if (c_mem_rd) begin
            rd_addr <= c_mem_addr;
            rd_cnt  <= lat - 4'd1;
        end else if (rd_cnt != 4'd0) begin
            rd_cnt  <= rd_cnt - 4'd1;
        end
        if (c_mem_rd && lat == 4'd1)        mem_rdata_m <= rd_word(c_mem_addr);
        else if (!c_mem_rd && rd_cnt == 4'd1) mem_rdata_m <= rd_word(rd_addr);
        else                                 mem_rdata_m <= {$urandom, $urandom};
    end

    // Reference memory, updated from the access rules only.
    logic [7:0] ref_b [0:255];
    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic junk_req();
        req_valid  = 1'($urandom_range(0, 1));
        req_we     = 1'($urandom);
        req_size   = 2'($urandom);
        req_signed = 1'($urandom);
        req_addr   = $urandom;
        req_wdata  = {$urandom, $urandom};
    endtask

    task automatic do_rst();
        @(negedge clk);
        reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // One transaction with full timing/data checking against the reference.
    task automatic run(input bit we, input logic [1:0] sz, input bit sg, input logic [31:0] addr,
                       input logic [63:0] wd, input int hold, output logic [63:0] got);
        int nb, dw, off, rd_n, rd_k, wr_n, wr_k, rsp_k, e_rsp_k, e_rd_k, e_wr_k;
        bit err, done;
        logic [31:0] al;
        logic [63:0] e_rdata, e_wdata;
        nb  = 1 << sz;
        dw  = int'(dwb);
        err = (nb > dw) || ((addr % nb) != 0);
        al  = addr & ~(32'(dw) - 32'd1);
        off = int'(addr - al);
        e_rdata = '0; e_wdata = '0; e_rd_k = 0; e_wr_k = 0;
        if (!err && !we) begin
            for (int i = 0; i < nb; i++) e_rdata[8*i +: 8] = ref_b[8'(addr + 32'(i))];
            if (sg && nb < dw && e_rdata[8*nb-1])
                for (int i = nb; i < dw; i++) e_rdata[8*i +: 8] = 8'hFF;
        end
        for (int i = 0; i < dw; i++)
            e_wdata[8*i +: 8] = (i >= off && i < off + nb) ? wd[8*(i-off) +: 8] : ref_b[8'(al + 32'(i))];
        if (err)            e_rsp_k = 1;
        else if (!we)       begin e_rd_k = 1; e_rsp_k = 2 + int'(lat); end
        else if (nb == dw)  begin e_wr_k = 1; e_rsp_k = 2; end
        else                begin e_rd_k = 1; e_wr_k = 2 + int'(lat); e_rsp_k = 3 + int'(lat); end

        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
        req_addr = addr; req_wdata = wd;
        chk("idle_rdy", 64'(c_req_ready), 64'd1);
        @(posedge clk);
        rd_n = 0; rd_k = 0; wr_n = 0; wr_k = 0; rsp_k = 0; done = 0; got = '0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (rsp_ready) begin done = 1; break; end
            if (c_mem_rd) begin rd_n++; rd_k = k; chk("rd_addr", 64'(c_mem_addr), 64'(al)); end
            if (c_mem_wr) begin
                wr_n++; wr_k = k;
                chk("wr_addr", 64'(c_mem_addr), 64'(al));
                chk("wdata", c_mem_wdata, e_wdata);
            end
            chk("busy_rdy", 64'(c_req_ready), 64'd0);
            if (c_rsp_valid) begin
                if (rsp_k == 0) rsp_k = k;
                chk("rdata", c_rsp_rdata, e_rdata);
                chk("err", 64'(c_rsp_err), 64'(err));
                got = c_rsp_rdata;
                if (k - rsp_k >= hold) begin rsp_ready = 1'b1; req_valid = 1'b0; end
                else junk_req();
            end else begin
                junk_req();
            end
        end
        rsp_ready = 1'b0; req_valid = 1'b0;
        if (!done) begin
            chk("timeout", 64'd0, 64'd1);
            do_rst();
        end else begin
            chk("post_rdy", 64'(c_req_ready), 64'd1);
            chk("post_vld", 64'(c_rsp_valid), 64'd0);
        end
        chk("rsp_cycle", 64'(rsp_k), 64'(e_rsp_k));
        chk("rd_count", 64'(rd_n), 64'(e_rd_k != 0));
        chk("wr_count", 64'(wr_n), 64'(e_wr_k != 0));
        if (e_rd_k != 0) chk("rd_cycle", 64'(rd_k), 64'(e_rd_k));
        if (e_wr_k != 0) chk("wr_cycle", 64'(wr_k), 64'(e_wr_k));
        if (we && !err)
            for (int i = 0; i < nb; i++) ref_b[8'(addr + 32'(i))] = wd[8*i +: 8];
    endtask

    // Sub-word store interrupted by reset the cycle after accept.
    task automatic mid_reset(input logic [31:0] addr);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd1; req_signed = 1'b0;
        req_addr = addr; req_wdata = {$urandom, $urandom};
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("rst_rd", 64'(c_mem_rd), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_rdy", 64'(c_req_ready), 64'd1);
        for (int k = 0; k < 6; k++) begin
            chk("rst_wr", 64'(c_mem_wr), 64'd0);
            chk("rst_vld", 64'(c_rsp_valid), 64'd0);
            @(negedge clk);
        end
    endtask

    task automatic rand_txns(input int n);
        logic [63:0] g;
        logic [1:0]  sz;
        logic [7:0]  lo;
        for (int t = 0; t < n; t++) begin
            sz = 2'($urandom);
            lo = 8'($urandom);
            if ($urandom_range(0, 3) != 0) lo = lo & ~(8'((1 << sz) - 1));
            run(1'($urandom), sz, 1'($urandom), 32'h100 + 32'(lo), {$urandom, $urandom},
                $urandom_range(0, 2), g);
        end
    endtask

    initial begin
        logic [63:0] g;
        cfg = 1'b0; reset = 1'b1; rsp_ready = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0;
        req_addr = '0; req_wdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 64'(c_req_ready), 64'd1);
        chk("rst_rsp", 64'(c_rsp_valid), 64'd0);
        chk("rst_strobes", 64'({c_mem_rd, c_mem_wr}), 64'd0);
        chk("rst_addr", 64'(c_mem_addr), 64'd0);
        chk("rst_rdata", c_rsp_rdata, 64'd0);
        reset = 1'b0;

        // Populate every word through full-width stores.
        for (int a = 32'h100; a < 32'h200; a += 4) run(1'b1, 2'd2, 1'b0, 32'(a), {$urandom, $urandom}, 0, g);

        run(1'b1, 2'd2, 1'b0, 32'h100, 64'h11223344, 0, g);
        run(1'b0, 2'd0, 1'b1, 32'h103, 64'h0, 0, g);        chk("lb_0x103", g, 64'h11);
        run(1'b1, 2'd0, 1'b0, 32'h101, 64'hAB, 0, g);
        run(1'b0, 2'd2, 1'b0, 32'h100, 64'h0, 0, g);        chk("sb_merge", g, 64'h1122AB44);
        run(1'b1, 2'd2, 1'b0, 32'h100, 64'h80001234, 0, g);
        run(1'b0, 2'd1, 1'b1, 32'h102, 64'h0, 0, g);        chk("lh_signed", g, 64'hFFFF8000);
        run(1'b0, 2'd1, 1'b0, 32'h102, 64'h0, 0, g);        chk("lh_unsigned", g, 64'h8000);
        run(1'b1, 2'd2, 1'b0, 32'h104, 64'hDEADBEEF, 0, g); chk("sw_rdata", g, 64'h0);
        run(1'b0, 2'd1, 1'b0, 32'h101, 64'h0, 0, g);
        run(1'b0, 2'd2, 1'b0, 32'h102, 64'h0, 0, g);
        run(1'b0, 2'd3, 1'b0, 32'h108, 64'h0, 0, g);
        run(1'b0, 2'd2, 1'b0, 32'h104, 64'h0, 5, g);        chk("held_lw", g, 64'hDEADBEEF);
        mid_reset(32'h10A);
        rand_txns(150);

        // Wide instance, longer read latency.
        @(negedge clk);
        cfg = 1'b1;
        do_rst();
        run(1'b1, 2'd0, 1'b0, 32'h105, 64'h5A, 0, g);
        run(1'b0, 2'd3, 1'b0, 32'h100, 64'h0, 0, g);
        run(1'b1, 2'd3, 1'b0, 32'h108, 64'h8877665544332211, 0, g);
        run(1'b0, 2'd3, 1'b1, 32'h108, 64'h0, 0, g);        chk("ld_0x108", g, 64'h8877665544332211);
        run(1'b0, 2'd2, 1'b1, 32'h10C, 64'h0, 0, g);        chk("lw_sext64", g, 64'hFFFFFFFF88776655);
        run(1'b0, 2'd3, 1'b0, 32'h104, 64'h0, 0, g);
        run(1'b0, 2'd3, 1'b0, 32'h108, 64'h0, 3, g);
        mid_reset(32'h116);
        rand_txns(150);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
